l2_port_scheduler: RTL

- Sequences the single shared line-wide memory port (L2 or physical memory) between the instruction-cache miss path (I) and the data-cache miss/writeback path (D).
- Registered FSM that grants one requester at a time and latches its address and write data at grant.
- Holds the downstream request stable until L2_resp, then returns a registered line and a one-cycle resp pulse to the winner.
- Fairness: round-robin with a bounded-consecutive-grant rule.

---
 rtl/l2_port_scheduler_pkg.sv | 27 ++
 rtl/l2_port_scheduler_if.sv | 36 +++
 rtl/l2_port_scheduler_fairness.sv | 33 +++
 rtl/l2_port_scheduler.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/l2_port_scheduler_pkg.sv
// Shared types for the L2 port scheduler: line/word types, FSM states and requester ids.
// Optional performance counters are enabled with the L2_PORT_SCHED_PERF_EN macro.
package l2_port_scheduler_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } l2_sched_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } l2_req_src_t;

  localparam int unsigned CONSEC_W = 3;
  typedef logic [CONSEC_W-1:0] consec_t;

  function automatic l2_req_src_t other_src(input l2_req_src_t s);
    return (s == SRC_I) ? SRC_D : SRC_I;
  endfunction

endpackage

// File: rtl/l2_port_scheduler_if.sv
// Bundle of the I-cache, D-cache and downstream L2 port signals around the scheduler.
interface l2_port_scheduler_if;

  // Handshake: a requester raises I_read / D_read / D_write (level) with address and data
  // stable, and keeps it high until its one-cycle *_resp pulse, dropping it right after.
  // The scheduler holds L2_* stable from grant until L2_resp is sampled high.
  l2_port_scheduler_pkg::lc3b_word I_address;
  logic                            I_read;
  l2_port_scheduler_pkg::lc3b_line I_rdata;
  logic                            I_resp;

  l2_port_scheduler_pkg::lc3b_word D_address;
  logic                            D_read;
  logic                            D_write;
  l2_port_scheduler_pkg::lc3b_line D_wdata;
  l2_port_scheduler_pkg::lc3b_line D_rdata;
  logic                            D_resp;

  l2_port_scheduler_pkg::lc3b_word L2_address;
  logic                            L2_read;
  logic                            L2_write;
  l2_port_scheduler_pkg::lc3b_line L2_wdata;
  l2_port_scheduler_pkg::lc3b_line L2_rdata;
  logic                            L2_resp;

  modport slave (
    input  I_address, I_read, D_address, D_read, D_write, D_wdata, L2_rdata, L2_resp,
    output I_rdata, I_resp, D_rdata, D_resp, L2_address, L2_read, L2_write, L2_wdata
  );

  modport master (
    output I_address, I_read, D_address, D_read, D_write, D_wdata, L2_rdata, L2_resp,
    input  I_rdata, I_resp, D_rdata, D_resp, L2_address, L2_read, L2_write, L2_wdata
  );

endinterface

// File: rtl/l2_port_scheduler_fairness.sv
// Combinational winner select between the I and D miss paths.
module l2_sched_fairness
  import l2_port_scheduler_pkg::*;
#(
  parameter int MAX_CONSEC = 2
) (
  input  logic        i_req,
  input  logic        d_req,
  input  l2_req_src_t last_grant,
  input  consec_t     consec,
  input  logic        prev_contend,
  output logic        grant_valid,
  output l2_req_src_t grant,
  output logic        contend
);

  localparam consec_t MAX_C = consec_t'(MAX_CONSEC);

  always_comb begin
    grant_valid = i_req | d_req;
    contend     = i_req & d_req;
    grant       = SRC_I;
    if (contend) begin
      // The loser of a contended grant has already waited once, so it always wins next.
      // Only a requester that arrived during an uncontended grant may be passed over.
      if (!prev_contend && (consec < MAX_C)) grant = last_grant;
      else                                   grant = other_src(last_grant);
    end else if (d_req) begin
      grant = SRC_D;
    end
  end

endmodule

// File: rtl/l2_port_scheduler.sv
// Shares one line-wide L2 port between the I-cache and D-cache miss paths.
// Define L2_PORT_SCHED_PERF_EN to add saturating grant/contention counters.
module l2_port_scheduler
  import l2_port_scheduler_pkg::*;
#(
  parameter bit D_FIRST    = 1'b1,
  parameter int MAX_CONSEC = 2
) (
  input  logic            clk,
  input  logic            rst,
  l2_port_scheduler_if.slave bus,
  output l2_sched_state_t dbg_state
`ifdef L2_PORT_SCHED_PERF_EN
  ,
  output logic [31:0]     perf_i_grants,
  output logic [31:0]     perf_d_grants,
  output logic [31:0]     perf_contend_cycles
`endif
);

  l2_sched_state_t state, next_state;
  l2_req_src_t     last_grant, grant;
  consec_t         consec;
  logic            prev_contend, grant_valid, contend;
  logic            do_grant, do_capture;
  logic            i_req, d_req, wr_grant;

  lc3b_word l2_address;
  lc3b_line l2_wdata, i_rdata, d_rdata;
  logic     l2_read, l2_write, i_resp, d_resp;

  assign i_req    = bus.I_read;
  assign d_req    = bus.D_read | bus.D_write;
  assign wr_grant = (grant == SRC_D) && bus.D_write;

  l2_sched_fairness #(.MAX_CONSEC(MAX_CONSEC)) u_fairness (
    .i_req        (i_req),
    .d_req        (d_req),
    .last_grant   (last_grant),
    .consec       (consec),
    .prev_contend (prev_contend),
    .grant_valid  (grant_valid),
    .grant        (grant),
    .contend      (contend)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    do_grant   = 1'b0;
    do_capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          do_grant   = 1'b1;
          next_state = (grant == SRC_D) ? D_BUSY : I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (bus.L2_resp) begin
          do_capture = 1'b1;
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l2_address   <= '0;
      l2_wdata     <= '0;
      l2_read      <= 1'b0;
      l2_write     <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
      last_grant   <= D_FIRST ? SRC_I : SRC_D;
      consec       <= '0;
      prev_contend <= 1'b1;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      if (do_grant) begin
        l2_address   <= (grant == SRC_D) ? bus.D_address : bus.I_address;
        if (wr_grant) l2_wdata <= bus.D_wdata;
        l2_read      <= !wr_grant;
        l2_write     <= wr_grant;
        last_grant   <= grant;
        prev_contend <= contend;
        if (!contend)                 consec <= '0;
        else if (grant != last_grant) consec <= consec_t'(1);
        else if (consec != '1)        consec <= consec + 1'b1;
      end
      if (do_capture) begin
        l2_read  <= 1'b0;
        l2_write <= 1'b0;
        if (state == I_BUSY) begin
          i_rdata <= bus.L2_rdata;
          i_resp  <= 1'b1;
        end else begin
          // A writeback completes without touching the last returned D line.
          if (!l2_write) d_rdata <= bus.L2_rdata;
          d_resp <= 1'b1;
        end
      end
    end
  end

  assign bus.L2_address = l2_address;
  assign bus.L2_wdata   = l2_wdata;
  assign bus.L2_read    = l2_read;
  assign bus.L2_write   = l2_write;
  assign bus.I_rdata    = i_rdata;
  assign bus.D_rdata    = d_rdata;
  assign bus.I_resp     = i_resp;
  assign bus.D_resp     = d_resp;
  assign dbg_state      = state;

`ifdef L2_PORT_SCHED_PERF_EN
  logic contend_cycle;
  assign contend_cycle = ((state == IDLE)   && contend) ||
                         ((state == I_BUSY) && d_req)   ||
                         ((state == D_BUSY) && i_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_i_grants       <= '0;
      perf_d_grants       <= '0;
      perf_contend_cycles <= '0;
    end else begin
      if (do_grant && (grant == SRC_I) && (perf_i_grants != '1))
        perf_i_grants <= perf_i_grants + 32'd1;
      if (do_grant && (grant == SRC_D) && (perf_d_grants != '1))
        perf_d_grants <= perf_d_grants + 32'd1;
      if (contend_cycle && (perf_contend_cycles != '1))
        perf_contend_cycles <= perf_contend_cycles + 32'd1;
    end
  end
`endif

endmodule
